player_draw_ctl: RTL and testbench

Sequencing controller for the player sprite ROM (64×64, 12-bit RGB, one-cycle registered read, two images: right-facing on `rgb`, left-facing on `rgb2`). It sits in the VGA pixel pipeline between the background stage and the output stage. Per pixel it generates the ROM address, latches player position and facing direction once per frame, and compensates the ROM read latency. It overlays the selected sprite pixel on the incoming pixel, with colour-key transparency.

---
 rtl/player_draw_ctl.sv | 230 +++++++++++++++++++++++
 tb/tb_player_draw_ctl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_draw_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : player_draw_ctl                                              |
// | Description : Player sprite sequencing stage of the VGA pixel pipeline.    |
// |               Generates the sprite ROM address and latches position and    |
// |               facing once per frame. Aligns the pixel stream with the      |
// |               one-cycle ROM read and overlays the sprite pixel, using a    |
// |               colour key for transparency.                                 |
// | Ports       : clk, rst                       - pixel clock, sync reset (H) |
// |               hcount_in/vcount_in            - current pixel coordinates  |
// |               hsync/vsync/hblnk/vblnk_in     - timing signals             |
// |               rgb_in                         - background pixel           |
// |               xpos/ypos                      - sprite top-left corner     |
// |               move_left/move_right           - direction requests         |
// |               rom_address                    - sprite ROM address (1 cyc) |
// |               rom_rgb/rom_rgb2               - ROM data right/left image  |
// |               *_out                          - 3-cycle delayed pixel data |
// |               facing_left                    - committed facing direction |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module player_draw_ctl #(
  parameter int          SPRITE_W  = 64,
  parameter int          SPRITE_H  = 64,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        move_left,
  input  logic        move_right,
  output logic [11:0] rom_address,
  input  logic [11:0] rom_rgb,
  input  logic [11:0] rom_rgb2,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        facing_left
);

  localparam logic [11:0] SPRITE_W12 = 12'(SPRITE_W);
  localparam logic [11:0] SPRITE_H12 = 12'(SPRITE_H);

  typedef enum logic [0:0] {
    FACE_RIGHT = 1'b0,
    FACE_LEFT  = 1'b1
  } face_state_t;

  face_state_t state, state_nxt;

  logic        req_left, req_left_nxt;
  logic        vsync_prev;
  logic        vs_rise;
  logic [10:0] x_lat, y_lat;

  // Stage 1 combinational terms
  logic [11:0] h12, v12, xl12, yl12;
  logic [5:0]  rel_x, rel_y;
  logic        in_box;

  // Delay line; timing packed as {hsync, vsync, hblnk, vblnk}
  logic [3:0]  tim_d1, tim_d2;
  logic [10:0] hcount_d1, hcount_d2, vcount_d1, vcount_d2;
  logic [11:0] rgb_d1, rgb_d2;
  logic        in_box_d1, in_box_d2;
  logic        facing_d1, facing_d2;

  logic [11:0] pix;

  // ---------------------------------------------------------------------------
  // Direction request and frame commit
  // ---------------------------------------------------------------------------
  always_comb begin
    req_left_nxt = req_left;
    if (move_left && !move_right) begin
      req_left_nxt = 1'b1;
    end else if (move_right && !move_left) begin
      req_left_nxt = 1'b0;
    end
  end

  assign vs_rise = vsync_in & ~vsync_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_left   <= 1'b0;
      vsync_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      req_left   <= req_left_nxt;
      vsync_prev <= vsync_in;
      if (vs_rise) begin
        x_lat <= xpos;
        y_lat <= ypos;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Facing FSM; commits the request value including this cycle's request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FACE_RIGHT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    facing_left = 1'b0;
    case (state)
      FACE_RIGHT: begin
        if (vs_rise && req_left_nxt) begin
          state_nxt = FACE_LEFT;
        end
      end
      FACE_LEFT: begin
        facing_left = 1'b1;
        if (vs_rise && !req_left_nxt) begin
          state_nxt = FACE_RIGHT;
        end
      end
      default: state_nxt = FACE_RIGHT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1: box test and ROM address. 12-bit compares keep a sprite near the
  // right/bottom screen edge from wrapping around to coordinate 0.
  // ---------------------------------------------------------------------------
  assign h12  = {1'b0, hcount_in};
  assign v12  = {1'b0, vcount_in};
  assign xl12 = {1'b0, x_lat};
  assign yl12 = {1'b0, y_lat};

  // Only the low six bits of the offset address the ROM; they depend only on
  // the low six bits of the operands.
  assign rel_x = hcount_in[5:0] - x_lat[5:0];
  assign rel_y = vcount_in[5:0] - y_lat[5:0];

  assign in_box = (h12 >= xl12) && (h12 < xl12 + SPRITE_W12) &&
                  (v12 >= yl12) && (v12 < yl12 + SPRITE_H12);

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_address <= '0;
      tim_d1      <= '0;
      hcount_d1   <= '0;
      vcount_d1   <= '0;
      rgb_d1      <= '0;
      in_box_d1   <= 1'b0;
      facing_d1   <= 1'b0;
    end else begin
      rom_address <= in_box ? {rel_y, rel_x} : 12'h000;
      tim_d1      <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
      hcount_d1   <= hcount_in;
      vcount_d1   <= vcount_in;
      rgb_d1      <= rgb_in;
      in_box_d1   <= in_box;
      facing_d1   <= facing_left;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: ROM registers its data while the side-band advances.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tim_d2    <= '0;
      hcount_d2 <= '0;
      vcount_d2 <= '0;
      rgb_d2    <= '0;
      in_box_d2 <= 1'b0;
      facing_d2 <= 1'b0;
    end else begin
      tim_d2    <= tim_d1;
      hcount_d2 <= hcount_d1;
      vcount_d2 <= vcount_d1;
      rgb_d2    <= rgb_d1;
      in_box_d2 <= in_box_d1;
      facing_d2 <= facing_d1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: composite. Image selection uses the facing sampled with the pixel
  // so a commit between stages cannot mix images within one pixel.
  // ---------------------------------------------------------------------------
  assign pix = facing_d2 ? rom_rgb2 : rom_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d2;
      vcount_out <= vcount_d2;
      hsync_out  <= tim_d2[3];
      vsync_out  <= tim_d2[2];
      hblnk_out  <= tim_d2[1];
      vblnk_out  <= tim_d2[0];
      if (in_box_d2 && !tim_d2[1] && !tim_d2[0] && (pix != KEY_COLOR)) begin
        rgb_out <= pix;
      end else begin
        rgb_out <= rgb_d2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_draw_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_player_draw_ctl                                           |
// | Description : Directed self-checking bench for player_draw_ctl with a      |
// |               registered-read sprite ROM model.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_player_draw_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, xpos, ypos;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        move_left, move_right;
  logic [11:0] rom_address;
  logic [11:0] rom_rgb  = 12'h000;
  logic [11:0] rom_rgb2 = 12'h000;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        facing_left;

  logic        key_zero = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  player_draw_ctl #(
    .SPRITE_W (64),
    .SPRITE_H (64),
    .KEY_COLOR(12'hF0F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .move_left  (move_left),
    .move_right (move_right),
    .rom_address(rom_address),
    .rom_rgb    (rom_rgb),
    .rom_rgb2   (rom_rgb2),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out),
    .facing_left(facing_left)
  );

  always #5 clk = ~clk;

  // Sprite ROM model: right image 0A5, left image 5C3, optional key at 0.
  always @(posedge clk) begin
    rom_rgb  <= (key_zero && rom_address == 12'h000) ? 12'hF0F : 12'h0A5;
    rom_rgb2 <= (key_zero && rom_address == 12'h000) ? 12'hF0F : 12'h5C3;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // tim = {hsync, vsync, hblnk, vblnk}
  task automatic set_pix(input logic [10:0] h, input logic [10:0] v,
                         input logic [11:0] rgb, input logic [3:0] tim);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = rgb;
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = tim;
  endtask

  task automatic filler;
    set_pix(11'd1500, 11'd1000, 12'h000, 4'b0000);
  endtask

  task automatic vsync_pulse;
    vsync_in = 1'b1;
    tick;
    vsync_in = 1'b0;
    tick;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/rom_address"}, 16'(rom_address), 16'h0000);
    chk({tag, "/rgb_out"},     16'(rgb_out),     16'h0000);
    chk({tag, "/hcount_out"},  16'(hcount_out),  16'h0000);
    chk({tag, "/vcount_out"},  16'(vcount_out),  16'h0000);
    chk({tag, "/timing"}, 16'({hsync_out, vsync_out, hblnk_out, vblnk_out, facing_left}), 16'h0000);
  endtask

  // One pixel followed by filler; address checked after 1 edge, output after 3.
  task automatic pix_check(input string tag, input logic [10:0] h, input logic [10:0] v,
                           input logic [11:0] rgb, input logic [3:0] tim,
                           input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
    set_pix(h, v, rgb, tim);
    tick;
    chk({tag, "/addr"}, 16'(rom_address), 16'(exp_addr));
    filler;
    tick;
    tick;
    chk({tag, "/rgb"},    16'(rgb_out),    16'(exp_rgb));
    chk({tag, "/hcount"}, 16'(hcount_out), 16'(h));
    chk({tag, "/vcount"}, 16'(vcount_out), 16'(v));
    chk({tag, "/timing"}, 16'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 16'(tim));
  endtask

  initial begin
    // Reset with busy inputs: every output must still read 0.
    rst        = 1'b1;
    xpos       = 11'd100;
    ypos       = 11'd50;
    move_left  = 1'b1;
    move_right = 1'b0;
    set_pix(11'd5, 11'd7, 12'hFFF, 4'b1111);
    tick;
    chk_all_zero("reset");
    tick;
    chk_all_zero("reset2");

    rst       = 1'b0;
    move_left = 1'b0;
    filler;
    tick;

    // Before any commit the sprite sits at (0,0) facing right.
    pix_check("origin", 11'd0, 11'd0, 12'h321, 4'b0000, 12'h000, 12'h0A5);

    vsync_pulse;
    pix_check("corner_tl", 11'd100, 11'd50,  12'h123, 4'b0000, 12'h000, 12'h0A5);
    pix_check("left_out",  11'd99,  11'd50,  12'h234, 4'b0000, 12'h000, 12'h234);
    pix_check("right_out", 11'd164, 11'd50,  12'h345, 4'b0000, 12'h000, 12'h345);
    pix_check("corner_br", 11'd163, 11'd113, 12'h456, 4'b1000, 12'hFFF, 12'h0A5);
    pix_check("below_out", 11'd100, 11'd114, 12'h567, 4'b0000, 12'h000, 12'h567);
    pix_check("addr",      11'd110, 11'd53,  12'h678, 4'b0000, 12'h0CA, 12'h0A5);
    pix_check("hblnk",     11'd101, 11'd50,  12'h789, 4'b0010, 12'h001, 12'h789);
    pix_check("vblnk",     11'd102, 11'd50,  12'h89A, 4'b0001, 12'h002, 12'h89A);

    // Colour key at address 0 is transparent.
    key_zero = 1'b1;
    pix_check("key",    11'd100, 11'd50, 12'h123, 4'b0000, 12'h000, 12'h123);
    pix_check("no_key", 11'd101, 11'd50, 12'h124, 4'b0000, 12'h001, 12'h0A5);
    key_zero = 1'b0;

    // Mid-frame left request waits for the next vsync rise.
    move_left = 1'b1;
    tick;
    move_left = 1'b0;
    tick;
    chk("face_hold", 16'(facing_left), 16'h0000);
    pix_check("face_pre", 11'd105, 11'd55, 12'h111, 4'b0000, 12'h145, 12'h0A5);
    chk("face_hold2", 16'(facing_left), 16'h0000);
    vsync_pulse;
    chk("face_commit", 16'(facing_left), 16'h0001);
    pix_check("face_left", 11'd105, 11'd55, 12'h111, 4'b0000, 12'h145, 12'h5C3);

    // Both requests high: facing unchanged across a commit.
    move_left  = 1'b1;
    move_right = 1'b1;
    vsync_pulse;
    chk("both_hold", 16'(facing_left), 16'h0001);
    move_left  = 1'b0;

    // Right request in the same cycle as the vsync rise is committed.
    vsync_in = 1'b1;
    tick;
    move_right = 1'b0;
    vsync_in   = 1'b0;
    tick;
    chk("same_cycle_req", 16'(facing_left), 16'h0000);

    // Position change mid-frame takes effect next frame.
    xpos = 11'd300;
    tick;
    pix_check("old_pos",      11'd100, 11'd50, 12'h222, 4'b0000, 12'h000, 12'h0A5);
    pix_check("new_pos_pre",  11'd300, 11'd50, 12'h456, 4'b0000, 12'h000, 12'h456);
    vsync_pulse;
    pix_check("new_pos",      11'd300, 11'd50, 12'h333, 4'b0000, 12'h000, 12'h0A5);
    pix_check("old_pos_gone", 11'd100, 11'd50, 12'h567, 4'b0000, 12'h000, 12'h567);

    // Right screen edge, facing left: no wrap to column 0.
    xpos      = 11'd2040;
    move_left = 1'b1;
    vsync_pulse;
    move_left = 1'b0;
    chk("edge_facing", 16'(facing_left), 16'h0001);
    pix_check("edge_2047", 11'd2047, 11'd50, 12'h444, 4'b0000, 12'h007, 12'h5C3);
    pix_check("edge_2040", 11'd2040, 11'd50, 12'h444, 4'b0000, 12'h000, 12'h5C3);
    pix_check("edge_wrap", 11'd0,    11'd50, 12'h111, 4'b0000, 12'h000, 12'h111);
    pix_check("edge_2039", 11'd2039, 11'd50, 12'h222, 4'b0000, 12'h000, 12'h222);

    // Reset mid-frame flushes the pipeline and returns to (0,0) facing right.
    set_pix(11'd2045, 11'd50, 12'h777, 4'b1000);
    tick;
    chk("pre_rst_addr", 16'(rom_address), 16'h0005);
    rst = 1'b1;
    tick;
    chk_all_zero("mid_reset");
    rst = 1'b0;
    filler;
    tick;
    chk("flush_hcount", 16'(hcount_out), 16'h0000);
    chk("flush_rgb",    16'(rgb_out),    16'h0000);
    pix_check("origin2", 11'd0,  11'd0, 12'h321, 4'b0000, 12'h000, 12'h0A5);
    pix_check("origin2_out", 11'd64, 11'd0, 12'h654, 4'b0000, 12'h000, 12'h654);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
